lsu_mem_ctrl: RTL and testbench

Sequencer between the CPU load/store stage and a single-port, word-wide synchronous data memory. It accepts one load/store request at a time using the 3-bit LSUOP encoding. It performs lane selection and sign/zero extension for loads. It performs read-modify-write for sub-word stores, because the memory has no byte enables. Misaligned accesses are rejected with an error response and never touch memory.

---
 rtl/lsu_mem_ctrl_if.sv | 32 +++
 rtl/lsu_mem_ctrl.sv | 155 +++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_ctrl_if.sv
// Bundles the CPU-side request/response handshake and the data-memory port of lsu_mem_ctrl.
// slave modport: the controller; master modport: the CPU stage plus the memory it drives.
// DATAMEM_ADDR_WIDTH must match the controller instance; mem_addr is a word address.
interface lsu_mem_ctrl_if #(
    parameter int DATAMEM_ADDR_WIDTH = 16
);
    logic                          req_valid;
    logic                          req_ready;
    logic [2:0]                    req_op;
    logic [31:0]                   req_addr;
    logic [31:0]                   req_wdata;
    logic                          resp_valid;
    logic                          resp_err;
    logic [31:0]                   resp_rdata;
    logic                          mem_re;
    logic                          mem_we;
    logic [DATAMEM_ADDR_WIDTH-3:0] mem_addr;
    logic [31:0]                   mem_wdata;
    logic [31:0]                   mem_rdata;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
               mem_re, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
               mem_re, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer to a word-wide single-port memory: lane select + extension, RMW for SB/SH.
// Latency from accept edge to resp_valid: misaligned 1, SW 2, loads 3, SB/SH 4 cycles.
// One request in flight; req_ready is high only in IDLE, so requests are held off while busy.
// Ports: clk/rst (async active-high); bus.slave carries req_*/resp_* toward the CPU and mem_* toward memory.
module lsu_mem_ctrl #(
    parameter int DATAMEM_ADDR_WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    lsu_mem_ctrl_if.slave bus
);
    localparam int AW = DATAMEM_ADDR_WIDTH;

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    typedef enum logic [2:0] {IDLE, READ, CAPT, WRITE, RESP, RESP_ERR} state_t;

    state_t      state;
    logic [2:0]  opLat;
    logic [1:0]  laneLat;
    logic [31:0] wdataLat;
    logic        reqMisaligned;

    // Address bits above AW are intentionally dropped (addresses wrap).
    logic unusedAddrBits;
    assign unusedAddrBits = ^bus.req_addr;

    always_comb begin
        reqMisaligned = 1'b0;
        case (bus.req_op)
            OP_LH, OP_LHU, OP_SH: reqMisaligned = bus.req_addr[0];
            OP_LW, OP_SW:         reqMisaligned = |bus.req_addr[1:0];
            default:              reqMisaligned = 1'b0;
        endcase
    end

    function automatic logic [31:0] loadExtend(input logic [2:0]  op,
                                               input logic [1:0]  lane,
                                               input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LBU:  r = {24'd0, b};
            OP_LHU:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // The memory has no byte enables, so sub-word stores rebuild the whole word.
    function automatic logic [31:0] storeMerge(input logic [2:0]  op,
                                               input logic [1:0]  lane,
                                               input logic [31:0] wdata,
                                               input logic [31:0] word);
        logic [31:0] m;
        m = word;
        if (op == OP_SB) begin
            m[{lane, 3'b000} +: 8] = wdata[7:0];
        end else begin
            m[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        end
        return m;
    endfunction

    // Outputs are registered alongside the state: each transition also loads the
    // output values belonging to the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            opLat          <= OP_LB;
            laneLat        <= 2'd0;
            wdataLat       <= 32'd0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= 32'd0;
            bus.mem_re     <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        opLat         <= bus.req_op;
                        laneLat       <= bus.req_addr[1:0];
                        wdataLat      <= bus.req_wdata;
                        bus.req_ready <= 1'b0;
                        if (reqMisaligned) begin
                            state          <= RESP_ERR;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= 32'd0;
                        end else if (bus.req_op == OP_SW) begin
                            // Full-word store needs no read.
                            state         <= WRITE;
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= bus.req_addr[AW-1:2];
                            bus.mem_wdata <= bus.req_wdata;
                        end else begin
                            state        <= READ;
                            bus.mem_re   <= 1'b1;
                            bus.mem_addr <= bus.req_addr[AW-1:2];
                        end
                    end
                end
                READ: begin
                    bus.mem_re <= 1'b0;
                    state      <= CAPT;
                end
                CAPT: begin
                    if (opLat == OP_SB || opLat == OP_SH) begin
                        bus.mem_wdata <= storeMerge(opLat, laneLat, wdataLat, bus.mem_rdata);
                        bus.mem_we    <= 1'b1;
                        state         <= WRITE;
                    end else begin
                        bus.resp_rdata <= loadExtend(opLat, laneLat, bus.mem_rdata);
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b0;
                        state          <= RESP;
                    end
                end
                WRITE: begin
                    bus.mem_we     <= 1'b0;
                    bus.resp_valid <= 1'b1;
                    bus.resp_err   <= 1'b0;
                    bus.resp_rdata <= 32'd0;
                    state          <= RESP;
                end
                RESP, RESP_ERR: begin
                    bus.resp_valid <= 1'b0;
                    bus.resp_err   <= 1'b0;
                    bus.req_ready  <= 1'b1;
                    state          <= IDLE;
                end
                default: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;
    logic clk;
    logic rst;

    lsu_mem_ctrl_if #(.DATAMEM_ADDR_WIDTH(16)) bus ();

    lsu_mem_ctrl #(.DATAMEM_ADDR_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nAsserts = 0;
    int nFails   = 0;

    // Memory behind the DUT plus a tb-side poke port for preloading.
    logic [31:0] mem    [0:16383];
    logic [31:0] refMem [0:16383];
    logic        pokeEn  = 1'b0;
    int          pokeIdx = 0;
    logic [31:0] pokeVal = 32'd0;

    always @(posedge clk) begin
        if (pokeEn) mem[pokeIdx] <= pokeVal;
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    end

    // Observations of the most recent transaction.
    int          lastRespCyc, lastReads, lastWrites, lastWeCyc;
    logic [31:0] lastRdata, lastWeAddr;
    logic        lastErr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] val);
        pokeEn  = 1'b1;
        pokeIdx = idx;
        pokeVal = val;
        refMem[idx] = val;
        @(posedge clk);
        #1;
        pokeEn = 1'b0;
    endtask

    // Reference model: architectural result of one request from the ISA-level rules.
    task automatic model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic err, output logic [31:0] rdata, output int lat,
                         output int nRd, output int nWr, output int wIdx);
        logic [31:0] w, b, h;
        int          lane, half;
        wIdx = int'((addr & 32'h0000_FFFF) >> 2);
        lane = int'(addr % 4);
        half = lane / 2;
        err  = ((op == 3'd1 || op == 3'd4 || op == 3'd6) && (addr % 2 != 0)) ||
               ((op == 3'd2 || op == 3'd7) && (addr % 4 != 0));
        w = refMem[wIdx];
        b = (w >> (8 * lane)) & 32'hFF;
        h = (w >> (16 * half)) & 32'hFFFF;
        rdata = 32'd0;
        nRd = 0; nWr = 0;
        if (err) begin
            lat = 1;
        end else if (op == 3'd7) begin
            lat = 2; nWr = 1;
            refMem[wIdx] = wdata;
        end else if (op == 3'd5) begin
            lat = 4; nRd = 1; nWr = 1;
            refMem[wIdx] = (w & ~(32'hFF << (8 * lane))) | ((wdata & 32'hFF) << (8 * lane));
        end else if (op == 3'd6) begin
            lat = 4; nRd = 1; nWr = 1;
            refMem[wIdx] = (w & ~(32'hFFFF << (16 * half))) | ((wdata & 32'hFFFF) << (16 * half));
        end else begin
            lat = 3; nRd = 1;
            case (op)
                3'd0:    rdata = (b >= 128) ? b + 32'hFFFF_FF00 : b;
                3'd1:    rdata = (h >= 32768) ? h + 32'hFFFF_0000 : h;
                3'd3:    rdata = b;
                3'd4:    rdata = h;
                default: rdata = w;
            endcase
        end
    endtask

    task automatic doTxn(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input string tag);
        logic        eErr;
        logic [31:0] eRdata;
        int          eLat, eRd, eWr, wIdx, waitCnt;
        model(op, addr, wdata, eErr, eRdata, eLat, eRd, eWr, wIdx);
        waitCnt = 0;
        while (bus.req_ready !== 1'b1 && waitCnt < 20) begin
            @(posedge clk); #1; waitCnt++;
        end
        chk({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk); #1;
        // Scramble inputs so any use of unlatched request fields shows up.
        bus.req_valid = 1'b0;
        bus.req_op    = 3'($urandom_range(0, 7));
        bus.req_addr  = $urandom();
        bus.req_wdata = $urandom();
        lastRespCyc = 0; lastReads = 0; lastWrites = 0; lastWeCyc = 0;
        lastWeAddr  = 32'd0; lastRdata = 32'hDEAD_DEAD; lastErr = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (bus.mem_re === 1'b1) lastReads++;
            if (bus.mem_we === 1'b1) begin
                lastWrites++;
                lastWeCyc  = c;
                lastWeAddr = 32'(bus.mem_addr);
            end
            if (bus.resp_valid === 1'b1) begin
                lastRespCyc = c;
                lastErr     = bus.resp_err;
                lastRdata   = bus.resp_rdata;
                break;
            end
        end
        chk({tag, ".latency"}, lastRespCyc, eLat);
        chk({tag, ".err"}, 32'(lastErr), 32'(eErr));
        chk({tag, ".rdata"}, lastRdata, eRdata);
        chk({tag, ".reads"}, lastReads, eRd);
        chk({tag, ".writes"}, lastWrites, eWr);
        if (eWr == 1) begin
            chk({tag, ".weCycle"}, lastWeCyc, eLat - 1);
            chk({tag, ".weAddr"}, lastWeAddr, wIdx);
        end
        chk({tag, ".memWord"}, mem[wIdx], refMem[wIdx]);
        @(posedge clk); #1;
        chk({tag, ".pulse"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, ".idleReady"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        int          respT [3];
        logic [31:0] respD [3];
        logic [2:0]  qOp   [3];
        logic [31:0] qAddr [3];
        logic [31:0] qExp  [3];
        logic        dErr;
        int          dLat, dRd, dWr, dIdx, nResp, idx, weSeen, rvSeen;
        logic [2:0]  rop;
        logic [31:0] raddr;

        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst.resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst.resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst.mem_re", 32'(bus.mem_re), 32'd0);
        chk("rst.mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst.mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst.mem_wdata", bus.mem_wdata, 32'd0);
        for (int i = 0; i < 16; i++) poke(i, $urandom());
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Lane select and extension on loads.
        poke(4, 32'h80FF_7F01);
        doTxn(3'd0, 32'h0000_0012, 32'd0, "LB.lane2");
        chk("LB.lane2.const", lastRdata, 32'hFFFF_FFFF);
        doTxn(3'd3, 32'h0000_0012, 32'd0, "LBU.lane2");
        chk("LBU.lane2.const", lastRdata, 32'h0000_00FF);
        doTxn(3'd1, 32'h0000_0012, 32'd0, "LH.half1");
        chk("LH.half1.const", lastRdata, 32'hFFFF_80FF);

        // Sub-word store read-modify-write.
        poke(4, 32'h1122_3344);
        doTxn(3'd5, 32'h0000_0011, 32'hAABB_CCDD, "SB.lane1");
        chk("SB.lane1.memConst", mem[4], 32'h1122_DD44);
        chk("SB.lane1.weCycConst", lastWeCyc, 3);

        // Full-word store skips the read.
        doTxn(3'd7, 32'h0000_0020, 32'hDEAD_BEEF, "SW");
        chk("SW.weAddrConst", lastWeAddr, 32'h0000_0008);
        chk("SW.memConst", mem[8], 32'hDEAD_BEEF);

        // Misaligned requests.
        doTxn(3'd2, 32'h0000_0006, 32'd0, "LW.misal");
        chk("LW.misal.errConst", 32'(lastErr), 32'd1);
        doTxn(3'd6, 32'h0000_0003, 32'h1234_5678, "SH.misal");
        chk("SH.misal.errConst", 32'(lastErr), 32'd1);

        // Upper address bits are ignored.
        doTxn(3'd7, 32'hABCD_0024, 32'h0BAD_F00D, "SW.wrap");
        chk("SW.wrap.weAddrConst", lastWeAddr, 32'h0000_0009);

        // req_valid held high across three loads.
        qOp[0] = 3'd0; qAddr[0] = 32'h0000_0009;
        qOp[1] = 3'd4; qAddr[1] = 32'h0000_000E;
        qOp[2] = 3'd2; qAddr[2] = 32'h0000_0024;
        for (int k = 0; k < 3; k++) model(qOp[k], qAddr[k], 32'd0, dErr, qExp[k], dLat, dRd, dWr, dIdx);
        chk("b2b.startReady", 32'(bus.req_ready), 32'd1);
        nResp = 0; idx = 0;
        bus.req_valid = 1'b1; bus.req_op = qOp[0]; bus.req_addr = qAddr[0]; bus.req_wdata = 32'd0;
        for (int t = 1; t <= 14; t++) begin
            @(posedge clk); #1;
            if (bus.resp_valid === 1'b1 && nResp < 3) begin
                respT[nResp] = t;
                respD[nResp] = bus.resp_rdata;
                nResp++;
            end
            if (bus.req_ready === 1'b1) begin
                idx++;
                if (idx < 3) begin
                    bus.req_op = qOp[idx]; bus.req_addr = qAddr[idx];
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
        end
        bus.req_valid = 1'b0;
        chk("b2b.count", nResp, 3);
        for (int k = 0; k < 3; k++) begin
            if (k < nResp) begin
                chk($sformatf("b2b.cycle%0d", k), respT[k], 3 + 4 * k);
                chk($sformatf("b2b.data%0d", k), respD[k], qExp[k]);
            end
        end

        // Reset during the CAPT cycle of an SH aborts without writing.
        poke(5, 32'h5566_7788);
        chk("rstSH.ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1; bus.req_op = 3'd6; bus.req_addr = 32'h0000_0016; bus.req_wdata = 32'h0000_1234;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rstSH.req_ready", 32'(bus.req_ready), 32'd1);
        chk("rstSH.mem_we", 32'(bus.mem_we), 32'd0);
        chk("rstSH.resp_valid", 32'(bus.resp_valid), 32'd0);
        weSeen = 0; rvSeen = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (bus.mem_we !== 1'b0) weSeen++;
            if (bus.resp_valid !== 1'b0) rvSeen++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.mem_we !== 1'b0) weSeen++;
            if (bus.resp_valid !== 1'b0) rvSeen++;
        end
        chk("rstSH.noWrite", weSeen, 0);
        chk("rstSH.noResp", rvSeen, 0);
        chk("rstSH.readyAfter", 32'(bus.req_ready), 32'd1);
        chk("rstSH.memUnchanged", mem[5], 32'h5566_7788);

        // Random traffic against the reference model.
        for (int i = 0; i < 150; i++) begin
            rop   = 3'($urandom_range(0, 7));
            raddr = ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 63));
            doTxn(rop, raddr, $urandom(), $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end
endmodule
